branch_predictor_btb: RTL
=========================

Name: branch_predictor_btb

Overview:
- Parametrised successor to the EX-stage next-PC/flush logic: adds a direct-mapped branch target buffer (BTB) with per-entry saturating counters.
- IF stage receives a registered-table prediction for the fetch PC.
- EX stage resolves branch/JAL/JALR, raises flush and redirect PC on mispredict, and trains the tables on the next clock edge.
- PC is word-addressed: sequential successor is pc + 1.

Parameters:
- XLEN, 32, datapath/PC width.
- ENTRIES, 64, BTB depth; power of 2, ≥ 2. IDX_W = log2(ENTRIES).
- TAG_W, 8, tag bits stored per entry; IDX_W + TAG_W ≤ XLEN.
- CTR_BITS, 2, saturating counter width, ≥ 1.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- if_pc  in  XLEN  fetch PC.
- if_pred_taken  out  1  predicted taken for if_pc.
- if_pred_target  out  XLEN  predicted next PC for if_pc.
- ex_valid  in  1  EX holds a valid, non-squashed instruction.
- ex_opcode  in  7  EX opcode; compared against `OP_B, `JAL, `JALR.
- ex_pc  in  XLEN  EX instruction PC.
- ex_rs1  in  XLEN  rs1 value (JALR base).
- ex_imm  in  XLEN  immediate.
- ex_cmp_result  in  XLEN  branch compare result; non-zero means taken.
- ex_pred_taken  in  1  if_pred_taken piped to EX.
- ex_pred_target  in  XLEN  if_pred_target piped to EX.
- flush  out  1  mispredict; squash IF/ID.
- redirect_pc  out  XLEN  correct next PC, valid when flush = 1.
- br_count  out  CNT_W  resolved control-transfer count.
- mispred_count  out  CNT_W  flush count.

Behaviour:
- Entry fields: valid, tag[TAG_W], target[XLEN], ctr[CTR_BITS], is_jump.
- Addressing: idx = pc[IDX_W-1:0]; tag = pc[IDX_W+TAG_W-1:IDX_W].
- Lookup (combinational from table registers, 0-cycle):
  - hit = valid[idx] && tag match.
  - if_pred_taken = hit && (is_jump || ctr MSB).
  - if_pred_target = if_pred_taken ? target : if_pc + 1.
- Resolve (combinational, active only when ex_valid; otherwise flush = 0):
  - is_ct = branch | jal | jalr.
  - act_taken = jal | jalr | (branch && ex_cmp_result != 0).
  - act_target: jal/branch = ex_pc + ex_imm; jalr = ex_rs1 + ex_imm. All sums mod 2^XLEN.
  - flush = (ex_pred_taken != act_taken) || (act_taken && ex_pred_target != act_target).
  - A non-CT instruction predicted taken (aliasing) also flushes.
  - redirect_pc = act_taken ? act_target : ex_pc + 1.
- Update (registered; visible at lookup from the cycle after the edge), on ex_valid && is_ct:
  - Hit, branch: ctr saturates up if taken, down if not (no wrap at 0 or 2^CTR_BITS-1). Target rewritten when taken.
  - Hit, jump: target rewritten; is_jump = 1.
  - Miss, act_taken: allocate/overwrite entry. valid = 1, tag, target; is_jump = jal|jalr; ctr = 2^(CTR_BITS-1) (weakly taken).
  - Miss, not taken: no write.
  - Non-CT with ex_valid: no table write. Also invalidates a hitting entry if it caused a flush.
- Same-cycle lookup and update to the same idx: lookup returns the old contents; no bypass.
- Counters:
  - br_count += 1 on ex_valid && is_ct.
  - mispred_count += 1 on flush.
  - Both saturate at 2^CNT_W - 1.
- Reset (rst_n = 0 at edge):
  - All valid = 0; counters = 0. Suppresses any same-cycle update.
  - Outputs after reset: if_pred_taken = 0, if_pred_target = if_pc + 1. flush follows inputs (0 while ex_valid = 0).
  - Reset mid-operation discards pending training.

Test Plan:
- Reset, then if_pc = 0x10 → if_pred_taken = 0, if_pred_target = 0x11; br_count = mispred_count = 0.
- Cold branch ex_pc = 0x10, imm = 0x8, cmp = 1, pred 0 → flush = 1, redirect = 0x18. Next cycle, if_pc = 0x10 → taken, target 0x18; mispred_count = 1.
- Same branch resolved not-taken 2× (CTR_BITS = 2): ctr 2→1→0. Lookup predicts not-taken after the first; third not-taken → no flush, ctr stays 0 (saturation).
- JALR at 0x20, rs1 = 0x100, imm = 0x4, pred target 0x90 → flush = 1, redirect = 0x104, entry target becomes 0x104, is_jump = 1.
- Alias: ex_pc = 0x10 + ENTRIES, different tag → miss, allocation overwrites idx 0x10; lookup of 0x10 then misses.
- Assert rst_n = 0 in the same cycle as a taken-branch update → no entry written; counters 0. Same-cycle lookup/update to one idx returns pre-update value.

Source files
------------

// File: rtl/branch_predictor_btb_if.sv
// Fetch-side prediction and EX-side resolve/flush signals of the branch predictor.
interface branch_predictor_btb_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic [XLEN-1:0]  if_pc;
  logic             if_pred_taken;
  logic [XLEN-1:0]  if_pred_target;
  logic             ex_valid;
  logic [6:0]       ex_opcode;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_rs1;
  logic [XLEN-1:0]  ex_imm;
  logic [XLEN-1:0]  ex_cmp_result;
  logic             ex_pred_taken;
  logic [XLEN-1:0]  ex_pred_target;
  logic             flush;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mispred_count;

  modport master (
    output if_pc, ex_valid, ex_opcode, ex_pc, ex_rs1, ex_imm, ex_cmp_result,
           ex_pred_taken, ex_pred_target,
    input  if_pred_taken, if_pred_target, flush, redirect_pc, br_count, mispred_count
  );

  modport slave (
    input  if_pc, ex_valid, ex_opcode, ex_pc, ex_rs1, ex_imm, ex_cmp_result,
           ex_pred_taken, ex_pred_target,
    output if_pred_taken, if_pred_target, flush, redirect_pc, br_count, mispred_count
  );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with saturating counters: 0-cycle IF lookup, EX resolve/flush,
// table training on the clock edge after resolve.
module branch_predictor_btb #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 64,
  parameter int TAG_W    = 8,
  parameter int CTR_BITS = 2,
  parameter int CNT_W    = 32
) (
  input  logic clk,
  input  logic rst_n,
  branch_predictor_btb_if.slave bp
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  typedef struct packed {
    logic                valid;
    logic [TAG_W-1:0]    tag;
    logic [XLEN-1:0]     target;
    logic [CTR_BITS-1:0] ctr;
    logic                is_jump;
  } entry_t;

  entry_t tbl [ENTRIES];

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  entry_t           if_e, ex_e;
  logic             if_hit, ex_hit;

  assign if_idx = bp.if_pc[IDX_W-1:0];
  assign if_tag = bp.if_pc[IDX_W+TAG_W-1:IDX_W];
  assign ex_idx = bp.ex_pc[IDX_W-1:0];
  assign ex_tag = bp.ex_pc[IDX_W+TAG_W-1:IDX_W];
  assign if_e   = tbl[if_idx];
  assign ex_e   = tbl[ex_idx];
  assign if_hit = if_e.valid && (if_e.tag == if_tag);
  assign ex_hit = ex_e.valid && (ex_e.tag == ex_tag);

  // Lookup reads registered state only, so a same-cycle update is not visible here.
  assign bp.if_pred_taken  = if_hit && (if_e.is_jump || if_e.ctr[CTR_BITS-1]);
  assign bp.if_pred_target = bp.if_pred_taken ? if_e.target : bp.if_pc + XLEN'(1);

  logic            is_br, is_jal, is_jalr, is_ct, act_taken, mispred;
  logic [XLEN-1:0] act_target;

  assign is_br      = bp.ex_opcode == OP_B;
  assign is_jal     = bp.ex_opcode == OP_JAL;
  assign is_jalr    = bp.ex_opcode == OP_JALR;
  assign is_ct      = is_br | is_jal | is_jalr;
  assign act_taken  = is_jal | is_jalr | (is_br && (bp.ex_cmp_result != '0));
  assign act_target = (is_jalr ? bp.ex_rs1 : bp.ex_pc) + bp.ex_imm;
  assign mispred    = (bp.ex_pred_taken != act_taken) ||
                      (act_taken && (bp.ex_pred_target != act_target));

  assign bp.flush       = bp.ex_valid && mispred;
  assign bp.redirect_pc = act_taken ? act_target : bp.ex_pc + XLEN'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i].valid <= 1'b0;
      bp.br_count      <= '0;
      bp.mispred_count <= '0;
    end else begin
      if (bp.ex_valid) begin
        if (is_ct) begin
          if (ex_hit) begin
            if (is_br) begin
              if (act_taken) begin
                if (ex_e.ctr != CTR_MAX) tbl[ex_idx].ctr <= ex_e.ctr + CTR_BITS'(1);
                tbl[ex_idx].target <= act_target;
              end else if (ex_e.ctr != '0) begin
                tbl[ex_idx].ctr <= ex_e.ctr - CTR_BITS'(1);
              end
            end else begin
              tbl[ex_idx].target  <= act_target;
              tbl[ex_idx].is_jump <= 1'b1;
            end
          end else if (act_taken) begin
            tbl[ex_idx] <= '{valid: 1'b1, tag: ex_tag, target: act_target,
                             ctr: CTR_INIT, is_jump: is_jal | is_jalr};
          end
        end else if (ex_hit && mispred) begin
          // A non-CT instruction that hit and was predicted taken is an alias; drop it.
          tbl[ex_idx].valid <= 1'b0;
        end
      end
      if (bp.ex_valid && is_ct && (bp.br_count != '1))
        bp.br_count <= bp.br_count + CNT_W'(1);
      if (bp.flush && (bp.mispred_count != '1))
        bp.mispred_count <= bp.mispred_count + CNT_W'(1);
    end
  end
endmodule
